// File: rtl/fan_speed_ramp_ctrl.sv
// Multi-level fan regulator: button edges select a speed level, and the
// applied PWM duty slews toward that level's target at a fixed rate.
module fan_speed_ramp_ctrl #(
  parameter int LEVEL_W   = 3,
  parameter int MAX_LEVEL = 7,
  parameter int PWM_W     = 8,
  parameter int RAMP_DIV  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up_in,
  input  logic               down_in,
  input  logic               off_in,
  output logic [LEVEL_W-1:0] level_out,
  output logic [PWM_W-1:0]   duty_out,
  output logic               pwm_out,
  output logic               ramping_out
);

  localparam int                 PRESC_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [LEVEL_W-1:0] MAX_LVL    = LEVEL_W'(MAX_LEVEL);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);

  logic               up_prev_q,   up_prev_d;
  logic               down_prev_q, down_prev_d;
  logic               off_prev_q,  off_prev_d;
  logic               armed_q,     armed_d;
  logic [LEVEL_W-1:0] level_q,     level_d;
  logic [PWM_W-1:0]   duty_q,      duty_d;
  logic [PRESC_W-1:0] presc_q,     presc_d;
  logic [PWM_W-1:0]   pwm_cnt_q,   pwm_cnt_d;
  logic               pwm_q,       pwm_d;

  logic               up_ev_s;
  logic               down_ev_s;
  logic               off_ev_s;
  logic               tick_s;
  logic [PWM_W-1:0]   target_s;

  // Rising-edge events; armed_q masks the first cycle out of reset so a
  // button held through reset is seen as already high, not as a new press.
  always_comb begin
    up_prev_d   = up_in;
    down_prev_d = down_in;
    off_prev_d  = off_in;
    armed_d     = 1'b1;
    up_ev_s     = armed_q & up_in   & ~up_prev_q;
    down_ev_s   = armed_q & down_in & ~down_prev_q;
    off_ev_s    = armed_q & off_in  & ~off_prev_q;
  end

  // Level selection: off wins, simultaneous up/down cancel, both ends saturate.
  always_comb begin
    level_d = level_q;
    if (off_ev_s) begin
      level_d = {LEVEL_W{1'b0}};
    end else if (up_ev_s && !down_ev_s) begin
      if (level_q >= MAX_LVL) begin
        level_d = MAX_LVL;
      end else begin
        level_d = level_q + LEVEL_W'(1);
      end
    end else if (down_ev_s && !up_ev_s) begin
      if (level_q == {LEVEL_W{1'b0}}) begin
        level_d = {LEVEL_W{1'b0}};
      end else begin
        level_d = level_q - LEVEL_W'(1);
      end
    end else begin
      level_d = level_q;
    end
  end

  // Target duty per level; the top level maps to full scale rather than the shifted value.
  always_comb begin
    target_s = {PWM_W{1'b0}};
    if (level_q == MAX_LVL) begin
      target_s = {PWM_W{1'b1}};
    end else begin
      target_s = PWM_W'(level_q) << (PWM_W - LEVEL_W);
    end
  end

  // Ramp prescaler and one-LSB duty slew per tick.
  always_comb begin
    tick_s  = (presc_q == PRESC_LAST);
    presc_d = presc_q + PRESC_W'(1);
    duty_d  = duty_q;
    if (tick_s) begin
      presc_d = {PRESC_W{1'b0}};
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
    if (tick_s && (duty_q < target_s)) begin
      duty_d = duty_q + PWM_W'(1);
    end else if (tick_s && (duty_q > target_s)) begin
      duty_d = duty_q - PWM_W'(1);
    end else begin
      duty_d = duty_q;
    end
  end

  // PWM carrier counter and compare.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    pwm_d     = (pwm_cnt_q < duty_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      off_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      level_q     <= {LEVEL_W{1'b0}};
      duty_q      <= {PWM_W{1'b0}};
      presc_q     <= {PRESC_W{1'b0}};
      pwm_cnt_q   <= {PWM_W{1'b0}};
      pwm_q       <= 1'b0;
    end else begin
      up_prev_q   <= up_prev_d;
      down_prev_q <= down_prev_d;
      off_prev_q  <= off_prev_d;
      armed_q     <= armed_d;
      level_q     <= level_d;
      duty_q      <= duty_d;
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pwm_q       <= pwm_d;
    end
  end

  assign level_out   = level_q;
  assign duty_out    = duty_q;
  assign pwm_out     = pwm_q;
  assign ramping_out = (duty_q != target_s);

endmodule

// File: tb/tb_fan_speed_ramp_ctrl.sv
// Directed bench for fan_speed_ramp_ctrl with RAMP_DIV=4 (full duty 255).
module tb_fan_speed_ramp_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_in = 1'b0;
  logic       down_in = 1'b0;
  logic       off_in = 1'b0;
  logic [2:0] level_out;
  logic [7:0] duty_out;
  logic       pwm_out;
  logic       ramping_out;

  int checks = 0;
  int failures = 0;

  fan_speed_ramp_ctrl #(
    .LEVEL_W(3), .MAX_LEVEL(7), .PWM_W(8), .RAMP_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .up_in(up_in), .down_in(down_in), .off_in(off_in),
    .level_out(level_out), .duty_out(duty_out), .pwm_out(pwm_out),
    .ramping_out(ramping_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_up();
    up_in = 1'b1; tick(1); up_in = 1'b0; tick(1);
  endtask

  task automatic pulse_down();
    down_in = 1'b1; tick(1); down_in = 1'b0; tick(1);
  endtask

  task automatic wait_duty(input int target, input int limit, output int n);
    n = 0;
    while (duty_out !== 8'(target) && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int n, pwm_hi, nz, prev, bad, steps, badstep, badgap, last_change, cnt;

    // 1: reset state and idle
    tick(3);
    chk("rst_level", level_out, 0);
    chk("rst_duty", duty_out, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ramping", ramping_out, 0);
    reset = 1'b0;
    pwm_hi = 0; nz = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      pwm_hi += int'(pwm_out);
      if (level_out != 3'd0 || duty_out != 8'd0 || ramping_out) nz++;
    end
    chk("idle_pwm_high", pwm_hi, 0);
    chk("idle_nonzero", nz, 0);

    // 2: held up gives a single step and a 32-tick ramp
    up_in = 1'b1;
    tick(1);
    chk("t2_level_1cyc", level_out, 1);
    chk("t2_ramping", ramping_out, 1);
    tick(9);
    n = 9;
    chk("t2_no_repeat", level_out, 1);
    up_in = 1'b0;
    while (duty_out !== 8'd32 && n < 200) begin
      tick(1);
      n++;
    end
    chk("t2_ramp_cycles_in_125_128", (n >= 125 && n <= 128), 1);
    chk("t2_duty", duty_out, 32);
    chk("t2_ramping_done", ramping_out, 0);
    tick(40);
    chk("t2_duty_hold", duty_out, 32);

    // 3: saturate up, then down to zero without underflow
    for (int i = 1; i <= 9; i++) begin
      pulse_up();
      chk($sformatf("t3_up%0d", i), level_out, (1 + i > 7) ? 7 : 1 + i);
    end
    wait_duty(255, 1200, n);
    chk("t3_duty_full", duty_out, 255);
    chk("t3_ramping_full", ramping_out, 0);
    bad = 0;
    prev = int'(duty_out);
    for (int i = 1; i <= 8; i++) begin
      down_in = 1'b1; tick(1);
      if (int'(duty_out) > prev) bad++;
      prev = int'(duty_out);
      down_in = 1'b0; tick(1);
      if (int'(duty_out) > prev) bad++;
      prev = int'(duty_out);
      chk($sformatf("t3_down%0d", i), level_out, (7 - i < 0) ? 0 : 7 - i);
    end
    n = 0;
    while (duty_out !== 8'd0 && n < 1200) begin
      tick(1);
      n++;
      if (int'(duty_out) > prev) bad++;
      prev = int'(duty_out);
    end
    tick(20);
    chk("t3_duty_zero", duty_out, 0);
    chk("t3_no_rise_in_decel", bad, 0);

    // 4: up+down cancel, off beats up, decel at one LSB per 4 cycles
    for (int i = 0; i < 5; i++) pulse_up();
    wait_duty(160, 1000, n);
    chk("t4_level5", level_out, 5);
    chk("t4_duty160", duty_out, 160);
    up_in = 1'b1; down_in = 1'b1;
    tick(1);
    chk("t4_updown_cancel", level_out, 5);
    up_in = 1'b0; down_in = 1'b0;
    tick(1);
    off_in = 1'b1; up_in = 1'b1;
    tick(1);
    chk("t4_off_wins", level_out, 0);
    off_in = 1'b0; up_in = 1'b0;
    prev = int'(duty_out);
    steps = 0; badstep = 0; badgap = 0; last_change = -1; n = 0;
    while (duty_out !== 8'd0 && n < 800) begin
      tick(1);
      n++;
      if (int'(duty_out) != prev) begin
        if (prev - int'(duty_out) != 1) badstep++;
        if (last_change >= 0 && n - last_change != 4) badgap++;
        last_change = n;
        steps++;
      end
      prev = int'(duty_out);
    end
    chk("t4_steps", steps, 160);
    chk("t4_step_size", badstep, 0);
    chk("t4_step_gap", badgap, 0);
    chk("t4_duty_zero", duty_out, 0);

    // 5: level 2 gives 64/256 PWM high time
    pulse_up(); pulse_up();
    wait_duty(64, 600, n);
    chk("t5_duty64", duty_out, 64);
    pwm_hi = 0;
    for (int w = 0; w < 4; w++) begin
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
        tick(1);
        cnt += int'(pwm_out);
      end
      pwm_hi += cnt;
      chk($sformatf("t5_window%0d", w), cnt, 64);
    end
    chk("t5_total", pwm_hi, 256);

    // 6a: reset mid-ramp with up held through it
    pulse_up(); pulse_up();
    wait_duty(100, 600, n);
    chk("t6_mid_ramp", duty_out, 100);
    up_in = 1'b1;
    reset = 1'b1;
    tick(1);
    chk("t6_rst_level", level_out, 0);
    chk("t6_rst_duty", duty_out, 0);
    chk("t6_rst_pwm", pwm_out, 0);
    chk("t6_rst_ramping", ramping_out, 0);
    reset = 1'b0;
    tick(10);
    chk("t6_held_no_event", level_out, 0);
    chk("t6_held_duty", duty_out, 0);
    up_in = 1'b0;
    tick(2);

    // 6b: prescaler restarts from 0 after reset
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    up_in = 1'b1;
    tick(1);
    chk("t6b_level", level_out, 1);
    chk("t6b_duty_r1", duty_out, 0);
    up_in = 1'b0;
    tick(1);
    chk("t6b_duty_r2", duty_out, 0);
    tick(1);
    chk("t6b_duty_r3", duty_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fan_speed_ramp_ctrl.md
Name: fan_speed_ramp_ctrl

Overview:
Parametrised successor to the 4-speed fan regulator. It provides a configurable number of speed levels with edge-triggered up/down/off buttons. Each level maps to a PWM duty target, and the applied duty ramps toward that target at a programmable rate, so the fan accelerates and decelerates smoothly. It sits between the debounced front-panel button logic and the fan motor driver. It drives a PWM pin plus status outputs.

Parameters:
LEVEL_W, 3, width of the level register and level_out.
MAX_LEVEL, 7, highest speed level; must be ≤ 2^LEVEL_W-1 and ≥ 1.
PWM_W, 8, width of the PWM counter and duty; must be ≥ LEVEL_W.
RAMP_DIV, 16, clock cycles per duty step of 1 LSB; must be ≥ 1.

Ports:
clk  in  1  single clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
up_in  in  1  speed-up button, synchronous and debounced; acts on rising edge.
down_in  in  1  speed-down button, synchronous and debounced; acts on rising edge.
off_in  in  1  force-off button; acts on rising edge.
level_out  out  LEVEL_W  current speed level, 0 = OFF.
duty_out  out  PWM_W  currently applied (ramped) duty.
pwm_out  out  1  PWM drive to the motor.
ramping_out  out  1  high while duty_out ≠ target duty.

Behaviour:
- Reset is synchronous, active-high, one clock. It has priority over everything else.
- On reset, these are all cleared to 0: level, duty, the PWM counter, the ramp prescaler, and the edge-detect registers. Outputs after reset: level_out=0, duty_out=0, pwm_out=0, ramping_out=0.
- Edge detection:
  - Each button has a registered previous sample. The event is input & ~prev.
  - Holding a button gives exactly one event; there is no auto-repeat.
  - A button already high when reset releases does not produce an event.
- Level update happens on the same posedge that first samples the rise, so level_out changes 1 cycle after the input asserts.
  - off event: level := 0. Highest priority; overrides up and down.
  - up event only: level := min(level+1, MAX_LEVEL). Saturates.
  - down event only: level := max(level-1, 0). Saturates.
  - up and down events in the same cycle: no change. Both edges are consumed.
- Target duty is combinational from level:
  - level == MAX_LEVEL → all ones (2^PWM_W-1).
  - otherwise → level << (PWM_W-LEVEL_W).
- Ramp prescaler:
  - Free-running counter 0..RAMP_DIV-1. It asserts tick when it equals RAMP_DIV-1, then wraps to 0.
  - RAMP_DIV=1 gives a tick every cycle.
- Duty update on tick:
  - duty < target → duty+1.
  - duty > target → duty-1.
  - duty == target → hold.
  - duty never changes without a tick.
- A level change mid-ramp retargets immediately. The ramp continues from the present duty; there is no jump and no prescaler restart.
- ramping_out = (duty ≠ target). It is combinational from registered state.
- PWM:
  - Free-running PWM_W-bit counter that wraps at 2^PWM_W-1 → 0.
  - pwm_out is registered: pwm_out <= (pwm_cnt < duty).
  - pwm_out lags counter and duty by 1 cycle.
  - duty=0 gives pwm_out constantly low. Full duty gives high for 2^PWM_W-1 of every 2^PWM_W cycles.
- No state machine beyond the level register. No illegal level values are reachable; level > MAX_LEVEL is impossible by construction.

Test Plan:
All scenarios use the default parameters except RAMP_DIV=4; full duty is then 255.
1. Reset held 3 cycles, then released with all buttons low for 300 cycles → level_out=0, duty_out=0, ramping_out=0, pwm_out never high.
2. up_in held high for 10 cycles → level_out=1 exactly 1 cycle after assertion, and stays 1 (no repeat). ramping_out=1; duty_out reaches 32 after 32 ticks (128 cycles). ramping_out then falls to 0.
3. Nine separate up pulses → level_out saturates at 7 and duty_out settles at 255. Then eight down pulses → level_out=0 and duty_out ramps to 0, never underflowing.
4. At level 5 with duty settled at 160:
   - Raise up_in and down_in in the same cycle → level stays 5.
   - Then pulse off_in together with up_in → level_out=0. duty_out decrements by 1 every 4 cycles from 160 down to 0.
5. Settle at level 2 (duty 64) and observe 1024 cycles → pwm_out high exactly 64 of every 256 consecutive cycles.
6. Assert reset while duty_out is mid-ramp at about 100 → on the following cycle all outputs are 0. After release the prescaler restarts from 0, and no spurious level change occurs if up_in was held through reset.
